// File: rtl/uart_tx_drain.sv
// ============================================================================
// uart_tx_drain : pops bytes from a TX FIFO and sends them as 8N1 UART frames.
// Optional even-parity bit when UART_TX_PARITY_EN is defined.   Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_drain #(
  parameter int unsigned CLK_FREQ = 25_000_000,
  parameter int unsigned BIT_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  output logic       fifo_read,
  input  logic [7:0] fifo_read_data,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
  localparam logic [15:0] BIT_END      = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign bit_end = (baud_q == BIT_END);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        if (enable && !fifo_empty) state_d = S_READ;
      end
      S_READ: begin
        baud_d  = 16'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // FIFO output register is valid now, one cycle after the pop
        baud_d    = 16'd0;
        shift_d   = fifo_read_data;
        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
        parity_d  = ^fifo_read_data;
`endif
        state_d   = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_d  = 16'd0;
          state_d = S_IDLE;
        end
      end
      default: begin
        baud_d  = 16'd0;
        state_d = S_IDLE;
      end
    endcase

    // Line level is registered from the next state so tx changes on the entry edge
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_read  = (state_q == S_READ);
  assign frame_done = (state_q == S_STOP) && bit_end;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_drain.sv
// Bench for uart_tx_drain: FIFO model, frame-decoding monitor and scoreboard.
`default_nettype none

module tb_uart_tx_drain;

  localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       fifo_empty = 1'b1;
  logic       fifo_read;
  logic [7:0] fifo_read_data = 8'h00;
  logic       tx;
  logic       busy;
  logic       frame_done;

  uart_tx_drain #(
    .CLK_FREQ(8_000_000),
    .BIT_RATE(1_000_000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .fifo_read_data(fifo_read_data),
    .tx            (tx),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // FIFO model: registered read data, valid the cycle after the pop
  logic [7:0] fifo_q[$];
  int underflow = 0;
  always @(posedge clk) begin
    if (fifo_read) begin
      if (fifo_q.size() > 0) fifo_read_data <= fifo_q.pop_front();
      else underflow++;
    end
  end
  always @(negedge clk) fifo_empty = (fifo_q.size() == 0);

  // Scoreboard of expected line frames, bit i = tx level during bit period i
  logic [10:0] exp_q[$];

  int          cyc = 0, busy_cnt = 0, read_cnt = 0, done_cnt = 0, frames = 0;
  int          last_start = 0, prev_start = 0;
  bit          mon_active = 1'b0;
  int          mon_cnt = 0;
  logic [10:0] mon_bits;
  bit          mon_glitch, mon_done_ok;

  always @(negedge clk) begin
    int bi;
    logic [10:0] e;
    cyc++;
    if (busy === 1'b1) busy_cnt++;
    if (fifo_read === 1'b1) read_cnt++;
    if (frame_done === 1'b1) done_cnt++;
    if (rst_n !== 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active  = 1'b1;
        mon_cnt     = 1;
        mon_bits    = '1;
        mon_bits[0] = 1'b0;
        mon_glitch  = 1'b0;
        mon_done_ok = 1'b0;
        prev_start  = last_start;
        last_start  = cyc;
      end
    end else begin
      bi = mon_cnt / CPB;
      if (mon_cnt % CPB == 0) mon_bits[bi] = tx;
      else if (tx !== mon_bits[bi]) mon_glitch = 1'b1;
      if (mon_cnt == NB * CPB - 1 && frame_done === 1'b1) mon_done_ok = 1'b1;
      mon_cnt++;
      if (mon_cnt == NB * CPB) begin
        mon_active = 1'b0;
        frames++;
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {21'd0, mon_bits}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("frame_bits", {21'd0, mon_bits}, {21'd0, e});
          chk("bit_hold", {31'd0, mon_glitch}, 32'd0);
          chk("frame_done_last_cycle", {31'd0, mon_done_ok}, 32'd1);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d, input logic par, input bit expected);
    fifo_q.push_back(d);
`ifdef UART_TX_PARITY_EN
    if (expected) exp_q.push_back({1'b1, par, d, 1'b0});
`else
    if (expected) exp_q.push_back({1'b1, 1'b1, d, 1'b0});
`endif
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(exp_q.size() == 0 && busy === 1'b0 && !mon_active) && n < budget);
    if (!(exp_q.size() == 0 && busy === 1'b0 && !mon_active))
      chk("idle_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int r0, b0, d0, f0, n, v_read, v_tx, v_busy;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h07, 1'b1};
    vecs[4] = '{8'h3C, 1'b0};
    vecs[5] = '{8'h80, 1'b1};
    vecs[6] = '{8'h01, 1'b1};
    vecs[7] = '{8'h5A, 1'b0};

    rst_n  = 1'b0;
    enable = 1'b0;
    step();
    step();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // Empty FIFO with enable high: nothing may happen
    enable = 1'b1;
    v_read = 0; v_tx = 0; v_busy = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (fifo_read !== 1'b0) v_read++;
      if (tx !== 1'b1) v_tx++;
      if (busy !== 1'b0) v_busy++;
    end
    chk("empty_no_read", v_read, 0);
    chk("empty_tx_high", v_tx, 0);
    chk("empty_not_busy", v_busy, 0);

    // Single-byte frames
    for (int i = 0; i < 8; i++) begin
      r0 = read_cnt; b0 = busy_cnt; d0 = done_cnt; f0 = frames;
      push(vecs[i].data, vecs[i].par, 1'b1);
      wait_idle(400);
      chk("single_reads", read_cnt - r0, 1);
      chk("single_busy_cycles", busy_cnt - b0, NB * CPB + 2);
      chk("single_frame_done", done_cnt - d0, 1);
      chk("single_frames", frames - f0, 1);
    end

    // Back-to-back 0x00 then 0xFF
    r0 = read_cnt; f0 = frames;
    push(8'h00, 1'b0, 1'b1);
    push(8'hFF, 1'b0, 1'b1);
    wait_idle(600);
    chk("b2b_reads", read_cnt - r0, 2);
    chk("b2b_frames", frames - f0, 2);
    chk("b2b_period", last_start - prev_start, NB * CPB + 3);

    // Enable dropped during DATA of 0x3C with a second byte queued
    r0 = read_cnt; f0 = frames;
    push(8'h3C, 1'b0, 1'b1);
    push(8'h99, 1'b0, 1'b0);
    n = 0;
    while (!(mon_active && mon_cnt >= 20) && n < 300) begin
      step();
      n++;
    end
    if (!(mon_active && mon_cnt >= 20)) chk("drop_timeout", 32'd0, 32'd1);
    enable = 1'b0;
    wait_idle(400);
    v_tx = 0; v_busy = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (tx !== 1'b1) v_tx++;
      if (busy !== 1'b0) v_busy++;
    end
    chk("drop_reads", read_cnt - r0, 1);
    chk("drop_frames", frames - f0, 1);
    chk("drop_tx_high", v_tx, 0);
    chk("drop_not_busy", v_busy, 0);
    chk("drop_fifo_left", fifo_q.size(), 1);

    // Reset during DATA bit 4 of 0x99; 0xC3 must follow as a fresh frame
    r0 = read_cnt; f0 = frames;
    push(8'hC3, 1'b0, 1'b1);
    enable = 1'b1;
    n = 0;
    while (!(mon_active && mon_cnt == 42) && n < 300) begin
      step();
      n++;
    end
    if (!(mon_active && mon_cnt == 42)) chk("rst_wait_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_fifo_read", {31'd0, fifo_read}, 32'd0);
    rst_n = 1'b1;
    wait_idle(400);
    chk("midrst_reads", read_cnt - r0, 2);
    chk("midrst_frames", frames - f0, 1);

    chk("fifo_underflow", underflow, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_drain.md
# uart_tx_drain

UART transmitter that acts as the read-side master of a peripheral byte FIFO. It pops bytes through the FIFO's `read`/`empty`/`read_data` interface and serialises each one onto `tx` as an 8N1 frame. It sits between the CPU-facing TX FIFO and the pad in the UART peripheral, and transmits back-to-back while the FIFO is non-empty.

## Interface
- `CLK_FREQ`, 25_000_000: clock frequency in Hz.
- `BIT_RATE`, 115200: line rate in bit/s. `CLKS_PER_BIT = CLK_FREQ / BIT_RATE`, using integer division; it must lie in 2..65535.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `enable`  input  1  permits starting a new frame; sampled only in IDLE.
- `fifo_empty`  input  1  FIFO empty flag.
- `fifo_read`  output  1  one-cycle pop request to the FIFO.
- `fifo_read_data`  input  8  FIFO output register; valid the cycle after `fifo_read`.
- `tx`  output  1  serial line; idles high.
- `busy`  output  1  high whenever state ≠ IDLE.
- `frame_done`  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- States: IDLE, READ, WAIT, START, DATA, PARITY (with macro only), STOP.
- IDLE:
  - If `enable`=1 and `fifo_empty`=0, go to READ.
  - Otherwise stay; `tx`=1.
- READ: lasts exactly one cycle. `fifo_read`=1 only in this state, decoded from state, so it is never high outside READ. Go to WAIT.
- WAIT: lasts one cycle. `fifo_read_data` is valid; latch it into an 8-bit shift register, clear the bit counter, go to START.
- START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA: 8 bits, LSB first. Each bit is held for `CLKS_PER_BIT` cycles; the shift register shifts right at each bit end. After bit 7, go to PARITY if present, else STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. `frame_done`=1 in the final cycle. Go to IDLE.
- Baud counter:
  - 16-bit, reloaded to 0 on every state entry.
  - The bit ends when the counter equals `CLKS_PER_BIT-1`.
  - Bit index: 3 bits, 0..7, no wrap past 7.
- `enable` deasserted mid-frame: the current frame completes; no new READ is issued.
- `fifo_empty` is ignored outside IDLE.
- Reset at any time, including mid-frame:
  - Next state is IDLE; `tx`=1, `busy`=0, `fifo_read`=0, `frame_done`=0.
  - A partially sent byte is discarded, not re-fetched.
- Reset values of all outputs: `tx`=1, `busy`=0, `fifo_read`=0, `frame_done`=0.

## Timing
- `tx` is registered and changes only on rising `clk` edges.
- Edge E0: IDLE samples `enable`=1 and `fifo_empty`=0.
  - Cycle after E0: READ, `fifo_read`=1.
  - Next cycle: WAIT.
  - `tx` falls on edge E0+2 (start of START).
- Frame length: 10·`CLKS_PER_BIT` cycles (11·`CLKS_PER_BIT` with parity).
- Back-to-back frames: IDLE → READ → WAIT adds exactly 3 extra `tx`-high cycles after the stop bit. Period = 10·`CLKS_PER_BIT` + 3.
- `busy` rises on the edge entering READ and falls on the edge entering IDLE.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state is inserted after DATA, holding `tx` = XOR of the 8 data bits (even parity) for `CLKS_PER_BIT` cycles.
  - Frame is 11 bits.
- Undefined: no PARITY state, 8N1 frame of 10 bits.

## Test plan
All scenarios use `CLK_FREQ`=8_000_000 and `BIT_RATE`=1_000_000, giving 8 clocks/bit.
- Single byte: FIFO holds 0xA5, `enable`=1.
  - Exactly one `fifo_read` pulse.
  - `tx` carries 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
  - `frame_done` pulses once; `busy` is high for 82 cycles.
- Empty FIFO: `fifo_empty`=1 for 200 cycles → `fifo_read`=0, `tx`=1, `busy`=0 throughout.
- Back-to-back: FIFO holds 0x00, 0xFF.
  - Two frames, separated by exactly 3 idle-high cycles after the first stop bit.
  - Payload bits all 0, then all 1.
- Enable drop: `enable`→0 during DATA of byte 0x3C with a second byte queued.
  - Frame 0x3C completes; no further `fifo_read`; `tx` stays 1.
- Reset mid-frame: `rst_n`=0 for 1 cycle during DATA bit 4.
  - Next edge: `tx`=1, `busy`=0.
  - After release with FIFO non-empty, a fresh READ is issued and a full new frame follows.
- With `UART_TX_PARITY_EN`: byte 0x07.
  - Parity bit 1; frame is 11 bits (88 cycles); stop bit follows the parity bit.
